// File: rtl/mem_port_arbiter.sv
// Two-port (fetch I / load-store D) arbiter in front of a single-port synchronous word RAM.
// Define MEM_ARB_FIXED_PRI_EN for fixed D-over-I priority; default build is round-robin.
module mem_port_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic              m_en,
    output logic              m_we,
    output logic [3:0]        m_be,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);

    typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, WAIT, RESP} state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t     state, state_nxt;
    logic       grant, grant_d, tie_d;
    logic       win, lat_we;
    logic [3:0] wait_cnt;

    // Byte-offset and out-of-range address bits are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

`ifdef MEM_ARB_FIXED_PRI_EN
    assign tie_d = 1'b1;
`else
    logic last_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= 1'b1;
        else if (state == RESP)
            last_grant <= win;
    end

    assign tie_d = ~last_grant;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_d   = 1'b0;
        m_en      = 1'b0;
        m_we      = 1'b0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant     = 1'b1;
                    grant_d   = (i_req && d_req) ? tie_d : d_req;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                m_en      = 1'b1;
                m_we      = lat_we;
                state_nxt = CAPTURE;
            end
            CAPTURE: state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT: begin
                if (wait_cnt == 4'd0)
                    state_nxt = RESP;
            end
            RESP: begin
                i_ack     = ~win;
                d_ack     = win;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= 4'd0;
        else if (state == CAPTURE)
            wait_cnt <= WAIT_LOAD;
        else if (state == WAIT && wait_cnt != 4'd0)
            wait_cnt <= wait_cnt - 4'd1;
    end

    // Request latches double as the RAM-side address/data outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win     <= 1'b0;
            lat_we  <= 1'b0;
            m_addr  <= '0;
            m_be    <= 4'd0;
            m_wdata <= 32'd0;
            i_rdata <= 32'd0;
            d_rdata <= 32'd0;
        end else begin
            if (grant) begin
                win     <= grant_d;
                lat_we  <= grant_d & d_we;
                m_addr  <= grant_d ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];
                m_be    <= (grant_d && d_we) ? d_be : 4'hF;
                m_wdata <= grant_d ? d_wdata : 32'd0;
            end
            if (state == CAPTURE) begin
                if (win)
                    d_rdata <= m_rdata;
                else
                    i_rdata <= m_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases plus randomized traffic against a
// transaction-level model (grant time, winner, RAM contents) kept in the bench.
module tb_mem_port_arbiter;

    localparam int W  = 0;
    localparam int WW = 3;
`ifdef MEM_ARB_FIXED_PRI_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        i_req, i_ack, d_req, d_we, d_ack, m_en, m_we;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, m_wdata, m_rdata;
    logic [3:0]  d_be, m_be;
    logic [9:0]  m_addr;

    logic        w_i_req, w_i_ack, w_d_req, w_d_we, w_d_ack, w_m_en, w_m_we;
    logic [31:0] w_i_addr, w_i_rdata, w_d_addr, w_d_wdata, w_d_rdata, w_m_wdata, w_m_rdata;
    logic [3:0]  w_d_be, w_m_be;
    logic [9:0]  w_m_addr;

    mem_port_arbiter #(.ADDR_W(10), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .reset(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    mem_port_arbiter #(.ADDR_W(10), .WAIT_CYCLES(WW)) u_dut_w (
        .clk(clk), .reset(rst),
        .i_req(w_i_req), .i_addr(w_i_addr), .i_rdata(w_i_rdata), .i_ack(w_i_ack),
        .d_req(w_d_req), .d_we(w_d_we), .d_addr(w_d_addr), .d_be(w_d_be), .d_wdata(w_d_wdata),
        .d_rdata(w_d_rdata), .d_ack(w_d_ack),
        .m_en(w_m_en), .m_we(w_m_we), .m_be(w_m_be), .m_addr(w_m_addr), .m_wdata(w_m_wdata),
        .m_rdata(w_m_rdata)
    );

    // Environment RAMs: synchronous read, byte-enabled write.
    logic [31:0] ram  [1024];
    logic [31:0] ram1 [1024];

    always @(posedge clk) begin
        if (m_en) begin
            m_rdata <= ram[m_addr];
            if (m_we)
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) ram[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (w_m_en) begin
            w_m_rdata <= ram1[w_m_addr];
            if (w_m_we)
                for (int b = 0; b < 4; b++)
                    if (w_m_be[b]) ram1[w_m_addr][8*b +: 8] <= w_m_wdata[8*b +: 8];
        end
    end

    // Reference model state
    logic [31:0] mdl [1024];
    int          cyc, free_cyc, acc_cyc, ack_cyc;
    bit          own, last_g, exp_we, h_d_ok;
    logic [9:0]  exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rd, h_i, h_d;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        acc_cyc  = -1;
        ack_cyc  = -1;
        free_cyc = 0;
        last_g   = 1'b1;
        h_i      = 32'd0;
        h_d      = 32'd0;
        h_d_ok   = 1'b1;
    endtask

    // Arbiter free + any request in this cycle => grant; ack 3+W cycles later,
    // next grant possible 4+W cycles later.
    task automatic model_eval();
        bit         win;
        logic [9:0] word;
        if (cyc >= free_cyc && (i_req || d_req)) begin
            if (i_req && d_req) win = FIXED ? 1'b1 : !last_g;
            else                win = d_req;
            last_g   = win;
            own      = win;
            word     = win ? d_addr[11:2] : i_addr[11:2];
            exp_addr = word;
            exp_we   = win && d_we;
            exp_be   = d_be;
            exp_wd   = d_wdata;
            if (exp_we) mdl[word] = merge(mdl[word], d_wdata, d_be);
            else        exp_rd = mdl[word];
            acc_cyc  = cyc + 1;
            ack_cyc  = cyc + 3 + W;
            free_cyc = cyc + 4 + W;
        end
    endtask

    task automatic step();
        model_eval();
        @(negedge clk);
        cyc++;
        chk("i_ack", i_ack, (ack_cyc == cyc) && !own);
        chk("d_ack", d_ack, (ack_cyc == cyc) && own);
        chk("m_en", m_en, acc_cyc == cyc);
        if (acc_cyc == cyc) begin
            chk("m_addr", m_addr, exp_addr);
            chk("m_we", m_we, exp_we);
            if (exp_we) begin
                chk("m_be", m_be, exp_be);
                chk("m_wdata", m_wdata, exp_wd);
            end else begin
                chk("m_be_rd", m_be, 4'hF);
            end
        end
        if (ack_cyc == cyc) begin
            if (!own)        h_i = exp_rd;
            else if (!exp_we) begin h_d = exp_rd; h_d_ok = 1'b1; end
            else             h_d_ok = 1'b0;
        end
        chk("i_rdata", i_rdata, h_i);
        if (h_d_ok) chk("d_rdata", d_rdata, h_d);
    endtask

    task automatic run_until_ack(input bit port, input int bound, output int ack_at);
        bit got;
        got    = 1'b0;
        ack_at = -1;
        for (int k = 0; k < bound && !got; k++) begin
            step();
            if (port ? d_ack : i_ack) begin
                got    = 1'b1;
                ack_at = cyc;
            end
        end
        chk(port ? "d_ack_timeout" : "i_ack_timeout", got, 1'b1);
        if (port) d_req = 1'b0;
        else      i_req = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_i_ack"}, i_ack, 0);
        chk({tag, "_d_ack"}, d_ack, 0);
        chk({tag, "_m_en"}, m_en, 0);
        chk({tag, "_m_we"}, m_we, 0);
        chk({tag, "_m_be"}, m_be, 0);
        chk({tag, "_m_addr"}, m_addr, 0);
        chk({tag, "_m_wdata"}, m_wdata, 0);
        chk({tag, "_i_rdata"}, i_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
    endtask

    function automatic logic [31:0] rnd_addr();
        return $urandom & 32'hFFFF_F03F;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err + 1);
        $fatal(1);
    end

    initial begin
        int          a, start, n, en_cnt, en_k, ack_k;
        logic [3:0]  order, exp_order;
        int          ac [4];
        logic [31:0] saved, addr_at_en, rd_at_ack;
        bit          allow;

        rst = 1'b0;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_be = 0; d_wdata = 0;
        w_i_req = 0; w_i_addr = 0; w_d_req = 0; w_d_we = 0; w_d_addr = 0; w_d_be = 0; w_d_wdata = 0;
        cyc = 0;
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] v;
            v      = $urandom;
            mdl[i] = v;
            ram[i] <= v;
            ram1[i] <= 32'd0;
        end
        mdl[0] = 32'h2408_0001;  ram[0] <= 32'h2408_0001;
        mdl[2] = 32'h1122_3344;  ram[2] <= 32'h1122_3344;
        mdl[4] = 32'h0BAD_F00D;  ram[4] <= 32'h0BAD_F00D;
        ram1[10'h0FF] <= 32'h5A5A_0FF0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("rst");
        rst = 1'b0;
        model_reset();

        // Single fetch: byte address 0x3000 aliases to word 0
        i_addr = 32'h0000_3000; i_req = 1'b1; start = cyc;
        run_until_ack(1'b0, 20, a);
        chk("fetch_lat", a - start, 3);
        chk("fetch_data", i_rdata, 32'h2408_0001);

        // Partial write then read back
        d_req = 1; d_we = 1; d_addr = 32'h8; d_be = 4'b0011; d_wdata = 32'hAABB_CCDD;
        run_until_ack(1'b1, 20, a);
        d_req = 1; d_we = 0;
        run_until_ack(1'b1, 20, a);
        chk("rmw_data", d_rdata, 32'h1122_CCDD);

        // Reset during the ACCESS cycle of a write to word 4
        saved = mdl[4];
        d_req = 1; d_we = 1; d_addr = 32'h10; d_be = 4'hF; d_wdata = 32'hDEAD_BEEF;
        step();
        rst = 1'b1; d_req = 1'b0;
        #1 chk_zero("midrst");
        mdl[4] = saved;
        @(posedge clk);
        #1 chk("word4_kept", ram[4], 32'h0BAD_F00D);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        d_req = 1; d_we = 0; d_addr = 32'h10;
        run_until_ack(1'b1, 20, a);
        chk("word4_read", d_rdata, 32'h0BAD_F00D);

        // Tie arbitration from a fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        i_req = 1; i_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h40;
        n = 0; order = 4'd0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            step();
            if (i_ack || d_ack) begin
                order[n] = d_ack;
                ac[n]    = cyc;
                n++;
            end
        end
        chk("tie_count", n, 4);
        exp_order = FIXED ? 4'b1111 : 4'b1010;
        chk("tie_order", order, exp_order);
        chk("tie_gap", ac[1] - ac[0], 4);
        d_req = 1'b0;
        run_until_ack(1'b0, 20, a);

        // Randomized traffic; the last stretch only drains outstanding requests
        for (int k = 0; k < 440; k++) begin
            allow = (k < 400);
            step();
            if (i_req) begin
                if (i_ack) begin
                    if (!allow || $urandom_range(1, 0) == 0) i_req = 1'b0;
                    else i_addr = rnd_addr();
                end
            end else if (allow && $urandom_range(2, 0) == 0) begin
                i_req = 1'b1; i_addr = rnd_addr();
            end
            if (d_req) begin
                if (d_ack) begin
                    if (!allow || $urandom_range(1, 0) == 0) d_req = 1'b0;
                    else begin
                        d_we = 1'($urandom); d_addr = rnd_addr();
                        d_be = 4'($urandom); d_wdata = $urandom;
                    end
                end
            end else if (allow && $urandom_range(2, 0) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom); d_addr = rnd_addr();
                d_be = 4'($urandom); d_wdata = $urandom;
            end
        end
        chk("drain_idle", {30'd0, i_req, d_req}, 0);

        // Wait states on the second instance
        w_d_req = 1; w_d_we = 0; w_d_addr = 32'h3FC;
        en_cnt = 0; en_k = -1; ack_k = -1; addr_at_en = 0; rd_at_ack = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (w_m_en) begin
                en_cnt++;
                if (en_k < 0) begin en_k = k; addr_at_en = {22'd0, w_m_addr}; end
            end
            if (w_d_ack && ack_k < 0) begin
                ack_k = k; rd_at_ack = w_d_rdata; w_d_req = 1'b0;
            end
        end
        chk("wait_en_count", en_cnt, 1);
        chk("wait_en_cycle", en_k, 1);
        chk("wait_m_addr", addr_at_en, 32'h0FF);
        chk("wait_latency", ack_k, 3 + WW);
        chk("wait_rdata", rd_at_ack, 32'h5A5A_0FF0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
